// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word blocks, round-robin replacement and flush.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_sa #(
   parameter int SETS  = 8,
   parameter int WAYS  = 2,
   parameter int WORDS = 2
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   input  logic        iflush,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int WOFF = $clog2(WORDS);
   localparam int IDX  = $clog2(SETS);
   localparam int TAG  = 30 - IDX - WOFF;
   localparam int WCW  = (WOFF > 0) ? WOFF : 1;
   localparam int RRW  = (WAYS > 1) ? $clog2(WAYS) : 1;

   typedef enum logic {IDLE, FILL} state_t;
   state_t state, next_state;

   logic [WAYS-1:0] valid [SETS];
   logic [TAG-1:0]  tags  [SETS][WAYS];
   logic [31:0]     data  [SETS][WAYS][WORDS];
   logic [RRW-1:0]  rr    [SETS];

   logic [TAG-1:0] req_tag, miss_tag;
   logic [IDX-1:0] req_idx, miss_idx;
   logic [WCW-1:0] req_woff, wc;
   logic [RRW-1:0] hit_way, req_victim, victim;
   logic           hit_raw, miss_start, fill_word, fill_last;
   logic           unused_ok;

   assign req_tag   = imemaddr[31 -: TAG];
   assign req_idx   = imemaddr[2+WOFF +: IDX];
   assign req_woff  = (WOFF > 0) ? imemaddr[2 +: WCW] : '0;
   assign unused_ok = ^imemaddr[1:0];

   // Descending scan so the lowest-index matching way is the one left standing.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      hit_raw = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (valid[req_idx][w] && (tags[req_idx][w] == req_tag)) begin
            hit_raw = 1'b1;
            hit_way = RRW'(w);
         end
      end
   end

   always_comb begin
      req_victim = rr[req_idx];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid[req_idx][w]) req_victim = RRW'(w);
      end
   end

   assign ihit       = (state == IDLE) && imemREN && hit_raw && !iflush;
   assign imemload   = ihit ? data[req_idx][hit_way][req_woff] : '0;
   assign miss_start = (state == IDLE) && imemREN && !hit_raw && !iflush;
   assign fill_word  = (state == FILL) && !iflush && !iwait;
   assign fill_last  = fill_word && (wc == WCW'(WORDS - 1));

   always_ff @(posedge CLK or negedge nRST) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!nRST) state <= IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      iREN       = 1'b0;
      iaddr      = '0;
      case (state)
         IDLE: if (miss_start) next_state = FILL;
         FILL: begin
            iREN  = 1'b1;
            iaddr = (32'({miss_tag, miss_idx}) << (WOFF + 2)) | (32'(wc) << 2);
            if (iflush || fill_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         miss_tag <= '0;
         miss_idx <= '0;
         wc       <= '0;
         victim   <= '0;
         for (int s = 0; s < SETS; s++) begin
            valid[s] <= '0;
            rr[s]    <= '0;
         end
      end else begin
         if (miss_start) begin
            miss_tag <= req_tag;
            miss_idx <= req_idx;
            wc       <= '0;
            victim   <= req_victim;
         end
         if (fill_word) wc <= wc + WCW'(1);
         if (fill_last && (victim == rr[miss_idx]))
            rr[miss_idx] <= (WAYS > 1) ? rr[miss_idx] + RRW'(1) : '0;
         // The victim is invalidated at the miss so a partially written block never hits.
         if (iflush) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
         end else if (miss_start) begin
            valid[req_idx][req_victim] <= 1'b0;
         end else if (fill_last) begin
            valid[miss_idx][victim] <= 1'b1;
         end
      end
   end

   // NOTE: tag and data arrays carry no reset; the valid bits alone qualify their contents.
   always_ff @(posedge CLK) begin
      if (fill_word) data[miss_idx][victim][wc] <= iload;
      if (fill_last) tags[miss_idx][victim]     <= miss_tag;
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit && (hit_count != '1))        hit_count  <= hit_count + 32'd1;
         if (miss_start && (miss_count != '1)) miss_count <= miss_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa: directed scenarios plus randomized fetches against a line-level model.
// Stats checks are compiled in when ICACHE_STATS_EN is defined.
module tb_icache_sa;

   localparam int SETS  = 8;
   localparam int WAYS  = 2;
   localparam int WORDS = 2;
   localparam int WOFF  = $clog2(WORDS);
   localparam int TLSB  = 2 + WOFF + $clog2(SETS);

   logic        CLK = 1'b0;
   logic        nRST, imemREN, iflush, ihit, iREN, iwait;
   logic [31:0] imemaddr, imemload, iaddr, iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count, miss_count;
`endif

   int tests = 0;
   int fails = 0;

   bit m_valid [SETS][WAYS];
   int m_tag   [SETS][WAYS];
   int m_rr    [SETS];
   int m_hits, m_misses;

   always #5 CLK = ~CLK;

   icache_sa #(.SETS(SETS), .WAYS(WAYS), .WORDS(WORDS)) dut (
      .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iflush(iflush),
      .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload)
`ifdef ICACHE_STATS_EN
      , .hit_count(hit_count), .miss_count(miss_count)
`endif
   );

   // Memory contents: an odd multiplier makes every word address map to a distinct value.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic int m_idx(input logic [31:0] a);
      return int'((a >> (2 + WOFF)) % SETS);
   endfunction

   function automatic int m_way(input logic [31:0] a);
      for (int w = 0; w < WAYS; w++)
         if (m_valid[m_idx(a)][w] && m_tag[m_idx(a)][w] == int'(a >> TLSB)) return w;
      return -1;
   endfunction

   task automatic m_fill(input logic [31:0] a);
      int s, v;
      s = m_idx(a);
      v = -1;
      for (int w = 0; w < WAYS && v < 0; w++) if (!m_valid[s][w]) v = w;
      if (v < 0) v = m_rr[s];
      if (v == m_rr[s]) m_rr[s] = (m_rr[s] + 1) % WAYS;
      m_valid[s][v] = 1'b1;
      m_tag[s][v]   = int'(a >> TLSB);
   endtask

   task automatic m_clear(input bit full);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
         if (full) m_rr[s] = 0;
      end
      if (full) begin
         m_hits   = 0;
         m_misses = 0;
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      nRST = 1'b0; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0; iwait = 1'b1; iload = '0;
      step();
      nRST = 1'b1;
      m_clear(1'b1);
      step();
   endtask

   // One fetch transaction: a predicted hit returns in the same cycle, a predicted miss
   // must issue every block word in order, hold iaddr under iwait, then hit once done.
   task automatic fetch(input logic [31:0] a, input int lat, input bit scramble, input string name);
      logic [31:0] base, wa;
      base = a & ~32'(WORDS * 4 - 1);
      imemREN = 1'b1; imemaddr = a; iflush = 1'b0; iwait = 1'b1; iload = '0;
      #1;
      if (m_way(a) >= 0) begin
         tests++;
         if ({ihit, imemload} !== {1'b1, mem(a)}) begin
            fails++;
            $display("FAIL %s hit: ihit=%b data=%h want ihit=1 data=%h", name, ihit, imemload, mem(a));
         end
         m_hits++;
         step();
         imemREN = 1'b0;
         return;
      end
      tests++;
      if ({ihit, iREN} !== 2'b00) begin
         fails++;
         $display("FAIL %s miss_cycle: ihit=%b iREN=%b want 0 0", name, ihit, iREN);
      end
      m_misses++;
      step();
      for (int w = 0; w < WORDS; w++) begin
         wa = base + 32'(w * 4);
         for (int l = 0; l <= lat; l++) begin
            if (scramble) begin
               imemaddr = $urandom;
               imemREN  = 1'($urandom_range(0, 1));
            end
            iwait = (l < lat);
            iload = mem(wa);
            #1;
            tests++;
            if ({iREN, ihit, iaddr} !== {2'b10, wa}) begin
               fails++;
               $display("FAIL %s fill w%0d: iREN=%b ihit=%b iaddr=%h want 1 0 %h",
                        name, w, iREN, ihit, iaddr, wa);
            end
            step();
         end
      end
      m_fill(a);
      imemREN = 1'b1; imemaddr = a; iwait = 1'b1; iload = '0;
      #1;
      tests++;
      if ({ihit, imemload, iREN} !== {1'b1, mem(a), 1'b0}) begin
         fails++;
         $display("FAIL %s after_fill: ihit=%b data=%h iREN=%b want 1 %h 0",
                  name, ihit, imemload, iREN, mem(a));
      end
      m_hits++;
      step();
      imemREN = 1'b0;
   endtask

   task automatic test_reset();
      nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h40; iflush = 1'b0; iwait = 1'b0; iload = '1;
      #2;
      tests++;
      if ({ihit, iREN, iaddr, imemload} !== '0) begin
         fails++;
         $display("FAIL reset_hold: ihit=%b iREN=%b iaddr=%h load=%h want all 0", ihit, iREN, iaddr, imemload);
      end
      step();
      step();
      nRST = 1'b1; imemREN = 1'b0; iwait = 1'b1;
      m_clear(1'b1);
      #1;
      tests++;
      if ({ihit, iREN, iaddr, imemload} !== '0) begin
         fails++;
         $display("FAIL reset_release: ihit=%b iREN=%b iaddr=%h load=%h want all 0", ihit, iREN, iaddr, imemload);
      end
`ifdef ICACHE_STATS_EN
      tests++;
      if ({hit_count, miss_count} !== 64'd0) begin
         fails++;
         $display("FAIL reset_stats: hits=%0d misses=%0d want 0 0", hit_count, miss_count);
      end
`endif
      step();
   endtask

   task automatic test_cold_miss();
      fetch(32'h40, 0, 1'b0, "cold_0x40");
      fetch(32'h44, 0, 1'b0, "warm_0x44");
   endtask

   task automatic test_latency();
      fetch(32'h100, 3, 1'b1, "lat_0x100");
      fetch(32'h104, 0, 1'b0, "lat_0x104");
   endtask

   task automatic test_assoc();
      do_reset();
      fetch(32'h000, 0, 1'b0, "assoc_0x000");
      fetch(32'h040, 1, 1'b0, "assoc_0x040");
      fetch(32'h080, 0, 1'b0, "assoc_0x080");
      fetch(32'h040, 0, 1'b0, "assoc_reread_0x040");
      fetch(32'h000, 0, 1'b0, "assoc_reread_0x000");
   endtask

   task automatic test_flush();
      fetch(32'h200, 0, 1'b0, "flush_fill_a");
      fetch(32'h248, 0, 1'b0, "flush_fill_b");
      imemREN = 1'b1; imemaddr = 32'h200; iflush = 1'b1;
      #1;
      tests++;
      if ({ihit, imemload} !== 33'd0) begin
         fails++;
         $display("FAIL flush_hit_forced: ihit=%b data=%h want 0 0", ihit, imemload);
      end
      step();
      iflush = 1'b0; imemREN = 1'b0;
      m_clear(1'b0);
      fetch(32'h200, 0, 1'b0, "flush_reread_a");
      fetch(32'h248, 0, 1'b0, "flush_reread_b");
      // Flush coinciding with a miss in IDLE must not start a fill.
      imemREN = 1'b1; imemaddr = 32'h300; iflush = 1'b1;
      #1;
      step();
      iflush = 1'b0; imemREN = 1'b0;
      m_clear(1'b0);
      #1;
      tests++;
      if ({iREN, iaddr} !== 33'd0) begin
         fails++;
         $display("FAIL flush_vs_miss: iREN=%b iaddr=%h want 0 0", iREN, iaddr);
      end
      step();
      // Flush in the middle of a fill aborts it; the word returned that cycle is dropped.
      imemREN = 1'b1; imemaddr = 32'h380; iwait = 1'b1;
      #1;
      step();
      iwait = 1'b0; iload = mem(32'h380);
      #1;
      tests++;
      if ({iREN, iaddr} !== {1'b1, 32'h380}) begin
         fails++;
         $display("FAIL flush_fill_start: iREN=%b iaddr=%h want 1 00000380", iREN, iaddr);
      end
      step();
      iflush = 1'b1; iload = mem(32'h384); imemREN = 1'b0;
      #1;
      step();
      iflush = 1'b0; iwait = 1'b1;
      m_clear(1'b0);
      #1;
      tests++;
      if ({iREN, ihit, iaddr} !== 34'd0) begin
         fails++;
         $display("FAIL flush_abort: iREN=%b ihit=%b iaddr=%h want 0 0 0", iREN, ihit, iaddr);
      end
      step();
      fetch(32'h380, 0, 1'b0, "flush_refetch");
   endtask

   task automatic test_reset_midfill();
      fetch(32'h0C0, 0, 1'b0, "rst_prefill");
      imemREN = 1'b1; imemaddr = 32'h1C0; iwait = 1'b1;
      #1;
      step();
      #2;
      nRST = 1'b0;
      #1;
      tests++;
      if ({iREN, ihit, iaddr} !== 34'd0) begin
         fails++;
         $display("FAIL reset_midfill: iREN=%b ihit=%b iaddr=%h want 0 0 0", iREN, ihit, iaddr);
      end
      step();
      nRST = 1'b1; imemREN = 1'b0;
      m_clear(1'b1);
      step();
      fetch(32'h0C0, 0, 1'b0, "rst_refetch");
   endtask

   task automatic test_random();
      logic [31:0] a;
      int r;
      for (int n = 0; n < 200; n++) begin
         r = $urandom_range(0, 11);
         if (r == 0) begin
            imemREN = 1'($urandom_range(0, 1)); imemaddr = $urandom; iflush = 1'b1;
            #1;
            tests++;
            if (ihit !== 1'b0) begin
               fails++;
               $display("FAIL rand_flush %0d: ihit=%b want 0", n, ihit);
            end
            step();
            iflush = 1'b0; imemREN = 1'b0;
            m_clear(1'b0);
         end else begin
            a = (32'($urandom_range(0, 5)) << TLSB) | (32'($urandom_range(0, SETS - 1)) << (2 + WOFF))
              | (32'($urandom_range(0, WORDS - 1)) << 2);
            fetch(a, $urandom_range(0, 2), (r == 1), $sformatf("rand_%0d", n));
         end
      end
   endtask

`ifdef ICACHE_STATS_EN
   task automatic test_stats();
      do_reset();
      fetch(32'h008, 0, 1'b0, "stats_m1");
      fetch(32'h010, 1, 1'b0, "stats_m2");
      fetch(32'h018, 0, 1'b0, "stats_m3");
      fetch(32'h00C, 0, 1'b0, "stats_h1");
      fetch(32'h014, 0, 1'b0, "stats_h2");
      tests++;
      if ({hit_count, miss_count} !== {32'd5, 32'd3}) begin
         fails++;
         $display("FAIL stats_counts: hits=%0d misses=%0d want 5 3", hit_count, miss_count);
      end
      iflush = 1'b1;
      step();
      iflush = 1'b0;
      m_clear(1'b0);
      tests++;
      if ({hit_count, miss_count} !== {32'(m_hits), 32'(m_misses)}) begin
         fails++;
         $display("FAIL stats_flush: hits=%0d misses=%0d want %0d %0d", hit_count, miss_count, m_hits, m_misses);
      end
      nRST = 1'b0;
      #1;
      tests++;
      if ({hit_count, miss_count} !== 64'd0) begin
         fails++;
         $display("FAIL stats_reset: hits=%0d misses=%0d want 0 0", hit_count, miss_count);
      end
      step();
      nRST = 1'b1;
      m_clear(1'b1);
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_cold_miss();
      test_latency();
      test_assoc();
      test_flush();
      test_reset_midfill();
      test_random();
`ifdef ICACHE_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
